leaf_stage_sequencer: RTL



---
 rtl/leaf_stage_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/leaf_stage_sequencer.sv
// Leaf stage sequencer: steps the grid through load/grow/merge/result on hub commands.
// Merge watchdog and deadlock reporting are built only with LEAF_SEQ_WATCHDOG_EN defined.
module leaf_stage_sequencer #(
    parameter int STAGE_WIDTH             = 3,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int MERGE_SETTLE            = 4,
    parameter int DEADLOCK_LIMIT          = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_round_start,
    input  logic                               cmd_valid,
    input  logic [1:0]                         state_signal,
    output logic                               cmd_ready,
    input  logic                               has_message_flying,
    input  logic                               has_odd_clusters,
    output logic [STAGE_WIDTH-1:0]             stage,
    output logic                               status_valid,
    output logic [1:0]                         status_data,
    input  logic                               status_ready,
    output logic                               result_valid,
    output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    output logic [31:0]                        cycle_counter,
    output logic                               deadlock
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_GROW,
        S_MERGE,
        S_REPORT,
        S_RESULT
    } state_t;

    localparam logic [STAGE_WIDTH-1:0] STG_IDLE   = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] STG_LOAD   = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] STG_GROW   = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] STG_MERGE  = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] STG_RESULT = STAGE_WIDTH'(4);

    localparam logic [1:0] CMD_GROW   = 2'b01;
    localparam logic [1:0] CMD_MERGE  = 2'b10;
    localparam logic [1:0] CMD_FINISH = 2'b11;

    localparam int QW = $clog2(MERGE_SETTLE + 1);
    localparam logic [QW-1:0] SETTLE = QW'(MERGE_SETTLE);

    state_t        state;
    logic [QW-1:0] quiet;
    logic [QW-1:0] quiet_inc;
    logic          quiet_done;
    logic          wd_hit;
    logic          dl_flag;

    // The cycle that brings the quiet run up to SETTLE is itself quiet.
    assign quiet_inc  = quiet + QW'(1);
    assign quiet_done = !has_message_flying && (quiet_inc == SETTLE);

`ifdef LEAF_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(DEADLOCK_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT = WW'(DEADLOCK_LIMIT);

    logic [WW-1:0] wd;
    logic [WW-1:0] wd_inc;
    logic          dl_q;

    assign wd_inc   = wd + WW'(1);
    assign wd_hit   = (state == S_MERGE) && (wd_inc == LIMIT);
    assign deadlock = dl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd   <= '0;
            dl_q <= 1'b0;
        end else begin
            if (state == S_MERGE) begin
                wd <= wd_inc;
            end else begin
                wd <= '0;
            end
            if (state == S_IDLE && new_round_start) begin
                dl_q <= 1'b0;
            end else if (wd_hit) begin
                dl_q <= 1'b1;
            end
        end
    end
`else
    logic unused_limit;

    assign wd_hit       = 1'b0;
    assign deadlock     = 1'b0;
    assign unused_limit = (DEADLOCK_LIMIT > 0);
`endif

    // Deadlock is sticky, so later reports in the same round still flag it.
    assign dl_flag = wd_hit | deadlock;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            stage             <= STG_IDLE;
            cmd_ready         <= 1'b0;
            status_valid      <= 1'b0;
            status_data       <= 2'b00;
            result_valid      <= 1'b0;
            iteration_counter <= '0;
            cycle_counter     <= '0;
            quiet             <= '0;
        end else begin
            result_valid <= 1'b0;
            if (state != S_IDLE && cycle_counter != 32'hFFFF_FFFF) begin
                cycle_counter <= cycle_counter + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (new_round_start) begin
                        state             <= S_LOAD;
                        stage             <= STG_LOAD;
                        iteration_counter <= '0;
                        cycle_counter     <= '0;
                    end
                end
                S_LOAD: begin
                    state     <= S_WAIT;
                    stage     <= STG_IDLE;
                    cmd_ready <= 1'b1;
                end
                S_WAIT: begin
                    if (cmd_valid) begin
                        case (state_signal)
                            CMD_GROW: begin
                                state     <= S_GROW;
                                stage     <= STG_GROW;
                                cmd_ready <= 1'b0;
                            end
                            CMD_MERGE: begin
                                state     <= S_MERGE;
                                stage     <= STG_MERGE;
                                cmd_ready <= 1'b0;
                                quiet     <= '0;
                            end
                            CMD_FINISH: begin
                                state        <= S_RESULT;
                                stage        <= STG_RESULT;
                                cmd_ready    <= 1'b0;
                                result_valid <= 1'b1;
                            end
                            default: begin
                                state <= S_WAIT;
                            end
                        endcase
                    end
                end
                S_GROW: begin
                    if (iteration_counter != '1) begin
                        iteration_counter <= iteration_counter
                                           + ITERATION_COUNTER_WIDTH'(1);
                    end
                    state     <= S_WAIT;
                    stage     <= STG_IDLE;
                    cmd_ready <= 1'b1;
                end
                S_MERGE: begin
                    quiet <= has_message_flying ? '0 : quiet_inc;
                    if (wd_hit || quiet_done) begin
                        state        <= S_REPORT;
                        stage        <= STG_IDLE;
                        status_valid <= 1'b1;
                        status_data  <= {dl_flag, has_odd_clusters};
                    end
                end
                S_REPORT: begin
                    if (status_ready) begin
                        state        <= S_WAIT;
                        status_valid <= 1'b0;
                        cmd_ready    <= 1'b1;
                    end
                end
                S_RESULT: begin
                    state <= S_IDLE;
                    stage <= STG_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    stage     <= STG_IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
